// File: rtl/imm_gen_pipe_if.sv
// Instruction-in / immediate-out handshake bundle for imm_gen_pipe.
// slave = the generator's view, master = the producer/consumer side.
interface imm_gen_pipe_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_inst, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport master (
    output in_valid, in_inst, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate generator with a 2-entry skid buffer and illegal-opcode counter.
// Optional macro IMM_GEN_PIPE_ZIMM_EN: CSR*I words decode as fmt 5 with zero-extended zimm.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  imm_gen_pipe_if.slave    bus,
  output logic [CNT_W-1:0] illegal_cnt
);
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } res_t;

  localparam logic [2:0] F_I = 3'd0, F_S = 3'd1, F_B = 3'd2, F_U = 3'd3,
                         F_J = 3'd4, F_Z = 3'd5, F_R = 3'd6, F_X = 3'd7;

  logic [31:0] inst;
  logic [31:0] i32;
  res_t        dec;

  assign inst = bus.in_inst;

  always_comb begin
    dec = '0;
    i32 = '0;
    case (inst[6:0])
      7'b0000011, 7'b0010011,
      7'b1100111, 7'b0001111: dec.fmt = F_I;
      7'b0011011:             dec.fmt = (XLEN == 64) ? F_I : F_X;
      7'b0100011:             dec.fmt = F_S;
      7'b1100011:             dec.fmt = F_B;
      7'b0010111, 7'b0110111: dec.fmt = F_U;
      7'b1101111:             dec.fmt = F_J;
      7'b0110011:             dec.fmt = F_R;
      7'b0111011:             dec.fmt = (XLEN == 64) ? F_R : F_X;
`ifdef IMM_GEN_PIPE_ZIMM_EN
      7'b1110011:             dec.fmt = inst[14] ? F_Z : F_I;
`else
      7'b1110011:             dec.fmt = F_I;
`endif
      default:                dec.fmt = F_X;
    endcase
    dec.ill = (dec.fmt == F_X);
    case (dec.fmt)
      F_I:     i32 = {{20{inst[31]}}, inst[31:20]};
      F_S:     i32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      F_B:     i32 = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      F_U:     i32 = {inst[31:12], 12'b0};
      F_J:     i32 = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: i32 = '0;
    endcase
    // Widen by replicating bit 31, then overwrite the low word; works for XLEN 32 and 64.
    dec.imm        = {XLEN{i32[31]}};
    dec.imm[31:0]  = i32;
    if (dec.fmt == F_Z) begin
      dec.imm      = '0;
      dec.imm[4:0] = inst[19:15];
    end
  end

  res_t main_q, skid_q;
  logic main_vld, skid_vld, rdy_q;
  logic accept;

  assign accept = bus.in_valid & rdy_q & ~flush;

  // in_ready is registered as "skid will be empty", so accept never coincides with a full skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (!main_vld || bus.out_ready) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
        rdy_q    <= 1'b1;
      end else begin
        main_vld <= accept;
        if (accept) main_q <= dec;
      end
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
      rdy_q    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= '0;
    else if (accept && dec.ill && (illegal_cnt != {CNT_W{1'b1}}))
      illegal_cnt <= illegal_cnt + 1'b1;
  end

  assign bus.in_ready    = rdy_q;
  assign bus.out_valid   = main_vld;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: directed test-plan cases plus randomized traffic
// against an arithmetic reference model; a separate monitor pops and compares outputs.
module tb_imm_gen_pipe;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic [CNT_W-1:0] illegal_cnt;

  imm_gen_pipe_if #(.XLEN(XLEN)) bus ();

  imm_gen_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];
  int   cnt_model = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w);
    exp_t   e;
    longint s, v;
    s = longint'($signed(w));
    v = 0;
    e.ill = 1'b0;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: e.fmt = 3'd0;
      7'b0011011: e.fmt = (XLEN == 64) ? 3'd0 : 3'd7;
      7'b0100011: e.fmt = 3'd1;
      7'b1100011: e.fmt = 3'd2;
      7'b0010111, 7'b0110111: e.fmt = 3'd3;
      7'b1101111: e.fmt = 3'd4;
      7'b0110011: e.fmt = 3'd6;
      7'b0111011: e.fmt = (XLEN == 64) ? 3'd6 : 3'd7;
`ifdef IMM_GEN_PIPE_ZIMM_EN
      7'b1110011: e.fmt = w[14] ? 3'd5 : 3'd0;
`else
      7'b1110011: e.fmt = 3'd0;
`endif
      default:    e.fmt = 3'd7;
    endcase
    case (e.fmt)
      3'd0: v = s >>> 20;
      3'd1: v = ((s >>> 25) << 5) | longint'(w[11:7]);
      3'd2: v = ((s >>> 31) << 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5)
              | (longint'(w[11:8]) << 1);
      3'd3: v = s & -64'sd4096;
      3'd4: v = ((s >>> 31) << 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11)
              | (longint'(w[30:21]) << 1);
      3'd5: v = longint'(w[19:15]);
      3'd7: e.ill = 1'b1;
      default: v = 0;
    endcase
    if (XLEN < 64) v = v & ((64'sd1 <<< XLEN) - 1);
    e.imm = v;
    return e;
  endfunction

  // One clock of stimulus: drive at negedge, record accepts just after.
  task automatic cycle(input bit v, input logic [31:0] w, input bit rdy, input bit fl);
    @(negedge clk);
    check("illegal_cnt", 64'(illegal_cnt), 64'(cnt_model));
    bus.in_valid  = v;
    bus.in_inst   = w;
    bus.out_ready = rdy;
    flush         = fl;
    #1;
    if (fl) q.delete();
    else if (bus.in_valid && bus.in_ready) begin
      exp_t e;
      e = model(w);
      q.push_back(e);
      if (e.ill && cnt_model < (1 << CNT_W) - 1) cnt_model++;
    end
  endtask

  // Monitor: a transfer happens at the next posedge whenever out_valid & out_ready.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) check("unexpected_output", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("out_imm", 64'(bus.out_imm), e.imm);
          check("out_fmt", 64'(bus.out_fmt), 64'(e.fmt));
          check("out_illegal", 64'(bus.out_illegal), 64'(e.ill));
        end
      end
    end
  end

  localparam logic [31:0] LW_M4  = 32'hFFC12083;
  localparam logic [31:0] BEQ_M4 = 32'hFE000EE3;
  localparam logic [31:0] AUIPC  = 32'h80000097;
  localparam logic [31:0] CSRRWI = 32'h3402D073;

  logic [6:0] ops [16] = '{7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b0011011,
                           7'b0100011, 7'b1100011, 7'b0010111, 7'b0110111, 7'b1101111,
                           7'b0110011, 7'b0111011, 7'b1110011, 7'b0000000, 7'b1111111,
                           7'b0101011};

  initial begin
    bus.in_valid = 1'b0; bus.in_inst = '0; bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_imm", 64'(bus.out_imm), 64'd0);
    check("rst_out_fmt", 64'(bus.out_fmt), 64'd0);
    check("rst_out_illegal", 64'(bus.out_illegal), 64'd0);
    check("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single-cycle latency and spot immediates
    cycle(1, LW_M4, 1, 0);
    cycle(1, BEQ_M4, 1, 0);
    check("lw_valid", 64'(bus.out_valid), 64'd1);
    check("lw_imm", 64'(bus.out_imm), 64'hFFFFFFFFFFFFFFFC);
    check("lw_fmt", 64'(bus.out_fmt), 64'd0);
    cycle(1, AUIPC, 1, 0);
    check("beq_imm", 64'(bus.out_imm), 64'hFFFFFFFFFFFFFFFC);
    check("beq_fmt", 64'(bus.out_fmt), 64'd2);
    cycle(1, CSRRWI, 1, 0);
    check("auipc_imm", 64'(bus.out_imm), 64'hFFFFFFFF80000000);
    check("auipc_fmt", 64'(bus.out_fmt), 64'd3);
    cycle(0, 0, 1, 0);
`ifdef IMM_GEN_PIPE_ZIMM_EN
    check("csrrwi_fmt", 64'(bus.out_fmt), 64'd5);
    check("csrrwi_imm", 64'(bus.out_imm), 64'd5);
`else
    check("csrrwi_fmt", 64'(bus.out_fmt), 64'd0);
    check("csrrwi_imm", 64'(bus.out_imm), 64'h340);
`endif
    cycle(0, 0, 0, 0);
    check("idle_valid", 64'(bus.out_valid), 64'd0);

    // Backpressure: A -> main, B -> skid, C stalls until the skid drains
    cycle(1, 32'h00100093, 0, 0);
    cycle(1, 32'h00200113, 0, 0);
    check("bp_ready_after_first", 64'(bus.in_ready), 64'd1);
    cycle(1, 32'h00300193, 0, 0);
    check("bp_ready_low", 64'(bus.in_ready), 64'd0);
    check("bp_hold_imm", 64'(bus.out_imm), 64'd1);
    cycle(1, 32'h00300193, 1, 0);
    check("bp_ready_still_low", 64'(bus.in_ready), 64'd0);
    cycle(1, 32'h00300193, 1, 0);
    check("bp_ready_back", 64'(bus.in_ready), 64'd1);
    check("bp_no_bubble_b", 64'(bus.out_valid), 64'd1);
    cycle(0, 0, 1, 0);
    check("bp_no_bubble_c", 64'(bus.out_valid), 64'd1);
    cycle(0, 0, 0, 0);
    check("bp_empty", 64'(bus.out_valid), 64'd0);
    check("bp_all_out", 64'(q.size()), 64'd0);

    // Flush with both entries full and an illegal word presented
    cycle(1, 32'h00500093, 0, 0);
    cycle(1, 32'h00600093, 0, 0);
    cycle(1, 32'h00000000, 0, 1);
    cycle(0, 0, 0, 0);
    check("flush_valid", 64'(bus.out_valid), 64'd0);
    check("flush_ready", 64'(bus.in_ready), 64'd1);

    // Saturation of the illegal counter
    for (int i = 0; i < 20; i++) cycle(1, 32'h0, 1, 0);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 1, 0);
    check("cnt_saturated", 64'(illegal_cnt), 64'd15);

    // Mid-operation reset clears everything, including the counter
    cycle(1, 32'h00000013, 0, 0);
    cycle(1, 32'h00000013, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", 64'(bus.out_valid), 64'd0);
    check("mrst_ready", 64'(bus.in_ready), 64'd1);
    check("mrst_cnt", 64'(illegal_cnt), 64'd0);
    q.delete();
    cnt_model = 0;
    bus.in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [31:0] w;
      bit fl;
      w = $urandom;
      if ($urandom_range(0, 9) < 8) w[6:0] = ops[$urandom_range(0, 15)];
      fl = ($urandom_range(0, 49) == 0);
      cycle($urandom_range(0, 9) < 7, w, fl ? 1'b0 : ($urandom_range(0, 9) < 6), fl);
    end
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
    check("final_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
